seq_divider_16by8: RTL
======================

Name: seq_divider_16by8

Overview:
- Sequential restoring divider, the inverse of the 8x8 multiply-accumulate datapath.
- Takes a 16-bit dividend (typically an accumulated MAC sum S) and an 8-bit divisor.
- Returns quotient and remainder one bit per clock.
- Sits downstream of the MAC unit and recovers scaled averages and operands from accumulated results, using a start/busy/done handshake.

Parameters:
- DW, 16, dividend and quotient width in bits.
- VW, 8, divisor and remainder width in bits (VW <= DW).

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous active-low reset; assert asynchronously, release synchronous to clock.
- start  input  1  request pulse; sampled on the rising edge; accepted only in IDLE or DONE.
- dividend  input  DW  dividend, captured on the accepting edge.
- divisor  input  VW  divisor, captured on the accepting edge.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse, results valid.
- quotient  output  DW  quotient, held until next accepted start.
- remainder  output  VW  remainder, held until next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset (reset_n=0, any time, including mid-division):
  - state=IDLE; busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0; iteration counter=0.
  - No result pulse after release.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Capture dividend into shift register Q and divisor into D.
  - Partial remainder R (VW+1 bits) cleared; counter=DW-1.
  - If the divisor is nonzero, next state is RUN; if zero, next state is DONE.
- RUN, each edge:
  - Shift: R = {R[VW-1:0], Q[DW-1]}, Q = Q<<1.
  - If R >= {1'b0,D}: R = R-D, Q[0]=1; else Q[0]=0.
  - Counter decrements; on the edge where counter==0, the last iteration completes and state moves to DONE.
- DONE:
  - done=1 for exactly one cycle; quotient=Q, remainder=R[VW-1:0].
  - Next edge: back to IDLE, unless start=1, which begins a new operation (back-to-back allowed).
- Latency: start accepted at E0 -> done high in the cycle after edge E0+DW, i.e. DW+1 cycles. Throughput is one result per DW+1 cycles.
- busy=1 exactly in cycles after E0 through after E0+DW-1 (DW cycles).
- start while busy=1 is ignored; operands are not recaptured and in-flight results are unaffected.
- Divide by zero:
  - Skip RUN; DONE in the cycle after E0 (1-cycle latency).
  - quotient = all ones (16'hFFFF), remainder = dividend[VW-1:0], div_by_zero=1.
  - div_by_zero clears on the next accepted start.
- Dividend < divisor: quotient=0, remainder=dividend (full DW iterations still run).
- Input changes after E0 have no effect.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Invariant on every normal done: quotient*divisor + remainder == dividend and remainder < divisor.

Decomposition:
- Shared package mac_pkg: DW/VW width constants shared with the MAC unit, and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module, div_step: combinational single restoring step, inputs (R, next bit, D) -> (R', q bit).
- FSM, counter and registers stay in the top.

Test Plan:
- Reset then start with dividend=65025, divisor=255 -> busy for 16 cycles; done pulse in cycle 17 after E0; quotient=255, remainder=0, div_by_zero=0.
- dividend=1000, divisor=7 -> quotient=142, remainder=6. Then back-to-back start in the DONE cycle with 65535/1 -> quotient=65535, remainder=0, no idle gap.
- dividend=100, divisor=200 -> quotient=0, remainder=100. Then dividend=5, divisor=0 -> done one cycle after start; quotient=16'hFFFF, remainder=5, div_by_zero=1, busy never asserted.
- Start 1000/7, then at cycle 5 pulse start with 50/3 and change inputs -> ignored; the result is still 142 r 6, delivered at the original latency.
- Start 65025/255, assert reset_n=0 asynchronously mid-RUN (cycle 8) -> all outputs 0 immediately; after release, no done pulse until a new start.
- Randomized sweep, 1000 operand pairs including divisor=1 and divisor=255 -> the invariant holds on every done.

Source files
------------

// File: rtl/mac_pkg.sv
// Constants shared between the MAC unit and the sequential divider that
// follows it: datapath widths and the divider FSM state encoding.
package mac_pkg;

  // Dividend/quotient width (the MAC accumulator width) and the
  // divisor/remainder width (the MAC operand width).
  localparam int MAC_DW = 16;
  localparam int MAC_VW = 8;

  // Divider FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_16by8_div_step.sv
// One restoring-division step. The step is purely combinational.
//   r_in   : partial remainder, always < d on entry
//   bit_in : next dividend bit shifted in at the bottom
//   d      : divisor (nonzero)
//   r_out  : partial remainder after the step, again < d
//   q_bit  : quotient bit produced by this step
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r_in,
  input  logic          bit_in,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] r_out,
  output logic          q_bit
);

  logic [VW:0] shl;
  logic [VW:0] diff;

  // r_in < d means shl <= 2d-1. With no borrow, shl-d < d, so the top bit
  // of diff is 0. With a borrow, the wrapped result is above 2^VW, so the
  // top bit is 1. The top bit therefore acts as the borrow flag.
  assign shl   = {r_in, bit_in};
  assign diff  = shl - {1'b0, d};
  assign q_bit = ~diff[VW];
  assign r_out = q_bit ? diff[VW-1:0] : shl[VW-1:0];

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider, DW-bit dividend by VW-bit divisor.
// It produces one quotient bit per clock and uses a start/busy/done handshake.
//   clock, reset_n : rising-edge clock; async active-low reset
//   start          : request, accepted in IDLE or DONE only
//   dividend       : DW-bit dividend, captured on the accepting edge
//   divisor        : VW-bit divisor, captured on the accepting edge
//   busy           : high while iterating (DW cycles)
//   done           : one-cycle result-valid pulse
//   quotient       : result, held until the next result is produced
//   remainder      : result, held until the next result is produced
//   div_by_zero    : set with done when the divisor was zero
module seq_divider_16by8
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int VW = MAC_VW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [VW-1:0] r_q, r_d;       // partial remainder, always < divisor
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW-1:0] step_r;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .r_in   (r_q),
    .bit_in (q_q[DW-1]),
    .d      (d_q),
    .r_out  (step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(DW - 1);
          if (divisor == '0) begin
            // The iterations are skipped and the defined result is delivered next cycle.
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        q_d   = {q_q[DW-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = {q_q[DW-2:0], step_q};
          rem_d   = step_r;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
